dmem_arbiter: RTL
=================

# dmem_arbiter

Arbiter and access sequencer for the single-port data memory behind the EXE/MEM pipeline register. It shares the memory between two requesters: the CPU MEM stage, which is driven by the EXE/MEM register outputs, and a DMA/loader port with a req/ack handshake. It counts out multi-cycle memory accesses. While a CPU access is pending, it raises `cpu_stall`, which the pipeline uses to freeze the PC, IF/ID, ID/EXE and EXE/MEM registers.

## Interface
- `ACCESS_CYCLES`, default 1: memory access length in cycles, legal values ≥1. A value of 1 gives the original single-cycle behaviour with no CPU stall.
- `STARVE_LIMIT`, default 4: number of consecutive CPU grants while DMA waits before DMA is forced. Used only when `DMEM_ARB_FAIR_EN` is defined.
- `clk` input 1: clock; all state updates on the rising edge.
- `clrn` input 1: reset, asynchronous, active-low.
- `mem_Alu_Result` input 32: CPU memory address.
- `mem_rb` input 32: CPU store data.
- `mem_wmem` input 1: CPU store request.
- `mem_m2reg` input 1: CPU load request.
- `cpu_rdata` output 32: CPU load data, valid in the CPU completion cycle.
- `cpu_stall` output 1: freeze the pipeline this cycle.
- `dma_req` input 1: DMA request; held until `dma_ack`.
- `dma_we` input 1: DMA write (1) or read (0).
- `dma_addr` input 32: DMA address.
- `dma_wdata` input 32: DMA write data.
- `dma_ack` output 1: one-cycle pulse marking DMA completion.
- `dma_rdata` output 32: DMA read data, registered and held until the next DMA read completes.
- `m_en` output 1: memory enable.
- `m_we` output 1: memory write enable.
- `m_addr` output 32: memory address.
- `m_wdata` output 32: memory write data.
- `m_rdata` input 32: memory read data, valid in the last cycle of an access.

## Operation
- `cpu_req = mem_wmem | mem_m2reg`. If both inputs are set, the access is treated as a store (`m_we=1`).
- States:
  - IDLE
  - CPU_BUSY
  - DMA_BUSY
- Access counter: `cnt`, 0..ACCESS_CYCLES-1.
- Arbitration in IDLE (combinational, same cycle):
  - CPU wins if `cpu_req`; otherwise DMA wins if `dma_req`.
  - The access starts in the grant cycle: `m_en=1`, and the winner's `addr`/`we`/`wdata` are muxed to the `m_*` outputs.
- If `ACCESS_CYCLES==1`, the access completes in the grant cycle and the state stays IDLE. Otherwise:
  - Next state is CPU_BUSY or DMA_BUSY with `cnt=1`.
  - `cnt` increments each cycle.
  - The access completes in the cycle where `cnt==ACCESS_CYCLES-1`; the state returns to IDLE.
- In BUSY states the owner's request is not re-sampled. The `m_*` outputs come from the owner's inputs; the CPU inputs are stable because the pipeline is stalled, and the DMA inputs are stable by handshake rule.
- CPU completion: `cpu_rdata = m_rdata` (combinational pass-through) and `cpu_stall=0`.
- `cpu_stall = cpu_req & ~(CPU access completing this cycle)`.
- DMA completion: `dma_ack=1` for one cycle. On a read, `dma_rdata <= m_rdata` at the clock edge ending that cycle.
- Back-to-back: after any completion, the next clock is IDLE and arbitration happens again immediately, with no dead cycle.
- When no access is active: `m_en=0`, `m_we=0`, and `m_addr`/`m_wdata`/`cpu_rdata` are 0.

## Timing
- CPU latency with the memory free: `cpu_stall` high for ACCESS_CYCLES-1 cycles.
- If DMA owns the memory, the CPU additionally waits for the remaining DMA cycles.
- DMA latency: from the first IDLE cycle in which DMA is granted, `dma_ack` occurs ACCESS_CYCLES-1 cycles later (the same cycle when ACCESS_CYCLES=1).
- DMA must keep `dma_req` and its operands stable until `dma_ack`. It may drop `dma_req` or issue a new request in the cycle after `dma_ack`.
- Reset values:
  - State IDLE, `cnt=0`, starvation counter 0, `dma_rdata=0`, `dma_ack=0`.
  - While `clrn=0`: `m_en=0`, `m_we=0`, `cpu_stall=0`.
- Reset mid-access aborts the access with no ack. After release, arbitration restarts from IDLE.

## Configuration
- `DMEM_ARB_FAIR_EN` defined: anti-starvation is enabled.
  - A counter increments on each CPU grant while `dma_req=1`.
  - The counter clears on a DMA grant or when `dma_req=0`.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants DMA even if `cpu_req=1`.
- Not defined: strict CPU priority. No counter logic is built, and DMA is served only when `cpu_req=0` in IDLE.

## Test plan
- ACCESS_CYCLES=1, CPU load at address 0x10 with memory word 0xDEADBEEF: `cpu_stall` stays 0 and `cpu_rdata`=0xDEADBEEF in the same cycle.
- ACCESS_CYCLES=3, CPU store to 0x20 with data 0x5A: `cpu_stall` is high for 2 cycles, `m_we` is high for 3 cycles, and the memory holds 0x5A afterwards.
- ACCESS_CYCLES=3, `dma_req` and `cpu_req` rise in the same cycle: the CPU completes first (stall 2), then the DMA is granted in the next cycle and `dma_ack` fires 2 cycles after that grant.
- ACCESS_CYCLES=2, DMA read in progress when `cpu_req` rises: `cpu_stall` is held for 1 cycle (remaining DMA) plus 1 cycle (own access), then goes low on CPU completion.
- `DMEM_ARB_FAIR_EN`, STARVE_LIMIT=4, `cpu_req` always high and `dma_req` high: DMA is granted after exactly 4 CPU accesses. Without the macro, `dma_ack` never fires.
- `clrn` pulsed low in cycle 1 of a 3-cycle DMA write: no `dma_ack`, `m_en` is 0 during reset, and the request is re-arbitrated from IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and a DMA/loader port, counts out multi-cycle accesses and stalls the
// pipeline while a CPU access is outstanding.
// Optional build macro DMEM_ARB_FAIR_EN adds DMA anti-starvation; without it
// the CPU has strict priority.
module dmem_arbiter #(
  parameter int ACCESS_CYCLES = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] mem_Alu_Result,
  input  logic [31:0] mem_rb,
  input  logic        mem_wmem,
  input  logic        mem_m2reg,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam bit MULTI = (ACCESS_CYCLES > 1);

  if (ACCESS_CYCLES < 1 || STARVE_LIMIT < 0) begin : g_bad_param
    $error("dmem_arbiter: ACCESS_CYCLES must be >= 1 and STARVE_LIMIT >= 0");
  end

  typedef enum logic [1:0] {IDLE, CPU_BUSY, DMA_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cpu_req;
  logic             grant_cpu, grant_dma;
  logic             cpu_own, dma_own;
  logic             last, cpu_done, dma_done;
  logic             dma_force;

  assign cpu_req = mem_wmem | mem_m2reg;

`ifdef DMEM_ARB_FAIR_EN
  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);
  logic [SC_W-1:0] starve_cnt;

  assign dma_force = dma_req && (starve_cnt == SC_LIMIT);

  // Count CPU grants that DMA had to sit through; reset once DMA is served or gives up
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      starve_cnt <= '0;
    end else if (!dma_req || grant_dma) begin
      starve_cnt <= '0;
    end else if (grant_cpu && starve_cnt != SC_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign dma_force = 1'b0;
`endif

  // Arbitration, output muxing and access sequencing for the current cycle
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    cpu_rdata = '0;

    if (clrn && state == IDLE) begin
      if (dma_force)    grant_dma = 1'b1;
      else if (cpu_req) grant_cpu = 1'b1;
      else if (dma_req) grant_dma = 1'b1;
    end

    cpu_own  = grant_cpu | (state == CPU_BUSY);
    dma_own  = grant_dma | (state == DMA_BUSY);
    // In IDLE cnt is 0, which equals CNT_LAST only for single-cycle accesses
    last     = (cnt == CNT_LAST);
    cpu_done = cpu_own & last;
    dma_done = dma_own & last;

    if (cpu_own) begin
      m_en    = 1'b1;
      m_we    = mem_wmem;
      m_addr  = mem_Alu_Result;
      m_wdata = mem_rb;
    end else if (dma_own) begin
      m_en    = 1'b1;
      m_we    = dma_we;
      m_addr  = dma_addr;
      m_wdata = dma_wdata;
    end

    if (cpu_done) cpu_rdata = m_rdata;

    case (state)
      IDLE: begin
        if (MULTI && grant_cpu) begin
          state_nxt = CPU_BUSY;
          cnt_nxt   = CNT_W'(1);
        end else if (MULTI && grant_dma) begin
          state_nxt = DMA_BUSY;
          cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  assign cpu_stall = clrn & cpu_req & ~cpu_done;
  assign dma_ack   = dma_done;

  // State and access counter; reset aborts any access in flight
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture DMA read data at the end of its completion cycle and hold it
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dma_rdata <= '0;
    end else if (dma_done && !dma_we) begin
      dma_rdata <= m_rdata[DATA_W-1:0];
    end
  end

endmodule
